// File: rtl/cache_refill_responder.sv
// Memory-side responder for the data-cache miss path: internal word store, fixed access latency,
// then LINE_WORDS-beat refill or writeback. Optional macro CRITICAL_WORD_FIRST_EN rotates refill order.
module cache_refill_responder #(
   parameter int LINE_WORDS      = 4,
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter int MEM_LATENCY     = 2
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic        iReqWrite,
   input  logic [31:0] iReqAddr,
   input  logic [31:0] iWrData,
   input  logic        iWrValid,
   output logic        oWrReady,
   output logic [31:0] oRdData,
   output logic        oRdValid,
   input  logic        iRdReady,
   output logic        oRdLast
);
   // state   | meaning
   // IDLE    | ready for a line request
   // LAT     | counting down the fixed access latency
   // XFER_RD | streaming refill beats to the controller
   // XFER_WR | absorbing writeback beats into the store

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(MEM_DEPTH_WORDS);
   localparam int LINE_W = IDX_W - OFF_W;

   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
   localparam logic [OFF_W-1:0] ONE_BEAT  = OFF_W'(1);
   localparam logic [3:0]       LAT_INIT  = 4'(MEM_LATENCY);

   typedef enum logic [1:0] {IDLE, LAT, XFER_RD, XFER_WR} state_t;

   state_t            state, state_nxt;
   logic              armed;
   logic              is_wr, is_wr_nxt;
   logic [LINE_W-1:0] line_idx, line_idx_nxt;
   logic [OFF_W-1:0]  beat_cnt, beat_nxt;
   logic [3:0]        lat_cnt, lat_nxt;
   logic [OFF_W-1:0]  rd_off;
   logic [IDX_W-1:0]  rd_idx, wr_idx;
   logic              mem_we;
   logic [31:0]       store [MEM_DEPTH_WORDS];

   // Bits above the store depth wrap away; byte-lane bits carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{iReqAddr[31:IDX_W+2], iReqAddr[OFF_W+1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
   logic [OFF_W-1:0] start_off, start_off_nxt;
   assign rd_off = start_off + beat_cnt;
`else
   assign rd_off = beat_cnt;
`endif

   assign rd_idx = {line_idx, rd_off};
   assign wr_idx = {line_idx, beat_cnt};

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state     <= IDLE;
         armed     <= 1'b0;
         is_wr     <= 1'b0;
         line_idx  <= '0;
         beat_cnt  <= '0;
         lat_cnt   <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
         start_off <= '0;
`endif
      end else begin
         state     <= state_nxt;
         armed     <= 1'b1;
         is_wr     <= is_wr_nxt;
         line_idx  <= line_idx_nxt;
         beat_cnt  <= beat_nxt;
         lat_cnt   <= lat_nxt;
`ifdef CRITICAL_WORD_FIRST_EN
         start_off <= start_off_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      is_wr_nxt    = is_wr;
      line_idx_nxt = line_idx;
      beat_nxt     = beat_cnt;
      lat_nxt      = lat_cnt;
`ifdef CRITICAL_WORD_FIRST_EN
      start_off_nxt = start_off;
`endif
      oReqReady    = 1'b0;
      oWrReady     = 1'b0;
      oRdValid     = 1'b0;
      oRdLast      = 1'b0;
      oRdData      = '0;
      mem_we       = 1'b0;

      case (state)
         IDLE: begin
            // armed holds ready low until the first edge after reset release
            oReqReady = armed;
            if (iReqValid && armed) begin
               is_wr_nxt    = iReqWrite;
               line_idx_nxt = iReqAddr[IDX_W+1:OFF_W+2];
`ifdef CRITICAL_WORD_FIRST_EN
               start_off_nxt = iReqWrite ? '0 : iReqAddr[OFF_W+1:2];
`endif
               beat_nxt     = '0;
               lat_nxt      = LAT_INIT;
               if (MEM_LATENCY == 0) state_nxt = iReqWrite ? XFER_WR : XFER_RD;
               else                  state_nxt = LAT;
            end
         end
         LAT: begin
            if (lat_cnt == 4'd0) state_nxt = is_wr ? XFER_WR : XFER_RD;
            else                 lat_nxt   = lat_cnt - 4'd1;
         end
         XFER_RD: begin
            oRdValid = 1'b1;
            oRdData  = store[rd_idx];
            oRdLast  = (beat_cnt == LAST_BEAT);
            if (iRdReady) begin
               beat_nxt = beat_cnt + ONE_BEAT;
               if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
            end
         end
         XFER_WR: begin
            oWrReady = 1'b1;
            if (iWrValid) begin
               mem_we   = 1'b1;
               beat_nxt = beat_cnt + ONE_BEAT;
               if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Store has no reset so contents survive an aborted transaction.
   always_ff @(posedge iClk) begin
      if (mem_we) store[wr_idx] <= iWrData;
   end

endmodule

// File: tb/tb_cache_refill_responder.sv
// Randomized scoreboard bench for cache_refill_responder; honours CRITICAL_WORD_FIRST_EN if defined.
module tb_cache_refill_responder;
   localparam int LW    = 4;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        iClk = 1'b0;
   logic        iRstN = 1'b1;
   logic        iReqValid = 1'b0;
   logic        oReqReady;
   logic        iReqWrite = 1'b0;
   logic [31:0] iReqAddr = '0;
   logic [31:0] iWrData = '0;
   logic        iWrValid = 1'b0;
   logic        oWrReady;
   logic [31:0] oRdData;
   logic        oRdValid;
   logic        iRdReady = 1'b0;
   logic        oRdLast;

   cache_refill_responder #(.LINE_WORDS(LW), .MEM_DEPTH_WORDS(DEPTH), .MEM_LATENCY(LAT)) dut (
      .iClk(iClk), .iRstN(iRstN), .iReqValid(iReqValid), .oReqReady(oReqReady),
      .iReqWrite(iReqWrite), .iReqAddr(iReqAddr), .iWrData(iWrData), .iWrValid(iWrValid),
      .oWrReady(oWrReady), .oRdData(oRdData), .oRdValid(oRdValid), .iRdReady(iRdReady),
      .oRdLast(oRdLast)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] mem_m [DEPTH];
   logic [31:0] written_q[$];
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Store word touched by beat n of a line request at byte address addr.
   function automatic int unsigned word_idx(input logic [31:0] addr, input int beat, input bit crit);
      int unsigned w, base, off, b;
      w    = addr >> 2;
      base = w - (w % LW);
      off  = w % LW;
      b    = crit ? (off + beat) % LW : beat;
      return (base + b) % DEPTH;
   endfunction

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   initial begin
      beat_t b;
      forever begin
         @(negedge iClk);
         if (iRstN && oRdValid && iRdReady) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got %h expected no beat", oRdData);
            end else begin
               b = exp_q.pop_front();
               check("rd_data", oRdData, b.data);
               check("rd_last", {31'b0, oRdLast}, {31'b0, b.last});
            end
         end
      end
   end

   task automatic reset_check();
      iRstN = 1'b0;
      #1;
      check("rst_req_ready", {31'b0, oReqReady}, 32'd0);
      check("rst_wr_ready",  {31'b0, oWrReady},  32'd0);
      check("rst_rd_valid",  {31'b0, oRdValid},  32'd0);
      check("rst_rd_last",   {31'b0, oRdLast},   32'd0);
      check("rst_rd_data",   oRdData,            32'd0);
      @(negedge iClk);
      @(negedge iClk);
      iRstN = 1'b1;
      #1;
      check("rel_req_ready_before_edge", {31'b0, oReqReady}, 32'd0);
      tick();
      check("rel_req_ready_after_edge", {31'b0, oReqReady}, 32'd1);
   endtask

   task automatic do_req(input bit wr, input logic [31:0] addr);
      int n;
      iReqWrite = wr;
      iReqAddr  = addr;
      iReqValid = 1'b1;
      n = 0;
      while (!oReqReady && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("req_timeout", 32'(n), 32'd0);
      tick();
      iReqValid = 1'b0;
      iReqWrite = ~wr;
      iReqAddr  = $urandom;
      check("req_ready_drop", {31'b0, oReqReady}, 32'd0);
      n = 0;
      while (!(oRdValid || oWrReady) && n < 40) begin
         tick();
         n++;
      end
      check("latency", 32'(n), 32'(LAT + 1));
   endtask

   task automatic writeback(input logic [31:0] addr, input logic [31:0] base, input bit gaps);
      int n;
      iWrValid = 1'b0;
      do_req(1'b1, addr);
      for (int i = 0; i < LW; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               iWrValid = 1'b0;
               iWrData  = $urandom;
               tick();
            end
         end
         iWrValid = 1'b1;
         iWrData  = base + 32'(i);
         n = 0;
         while (!oWrReady && n < 50) begin
            tick();
            n++;
         end
         if (n >= 50) check("wr_timeout", 32'(n), 32'd0);
         tick();
         mem_m[word_idx(addr, i, 1'b0)] = base + 32'(i);
      end
      iWrValid = 1'b0;
      check("wr_done_idle", {31'b0, oReqReady}, 32'd1);
      check("wr_done_ready", {31'b0, oWrReady}, 32'd0);
   endtask

   // mode 0: always ready, 1: random ready, 2: stall 3 cycles on beat 1, 3: reset after beat 1
   task automatic refill(input logic [31:0] addr, input int mode);
      int n, done, stall;
      beat_t b;
      exp_q.delete();
      for (int i = 0; i < LW; i++) begin
         b.data = mem_m[word_idx(addr, i, CWF)];
         b.last = (i == LW - 1);
         exp_q.push_back(b);
      end
      iRdReady = 1'b0;
      do_req(1'b0, addr);
      stall = 3;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         done = LW - exp_q.size();
         case (mode)
            1: iRdReady = 1'($urandom_range(0, 1));
            2: begin
               if (done == 1 && stall > 0) begin
                  iRdReady = 1'b0;
                  check("stall_valid", {31'b0, oRdValid}, 32'd1);
                  check("stall_data", oRdData, exp_q[0].data);
                  stall--;
               end else iRdReady = 1'b1;
            end
            3: begin
               if (done == 2) begin
                  iRdReady = 1'b0;
                  #2;
                  reset_check();
                  exp_q.delete();
                  return;
               end else iRdReady = 1'b1;
            end
            default: iRdReady = 1'b1;
         endcase
         tick();
         n++;
      end
      if (n >= 200) check("rd_timeout", 32'(n), 32'd0);
      iRdReady = 1'b0;
      check("rd_done_idle", {31'b0, oReqReady}, 32'd1);
      check("rd_done_valid", {31'b0, oRdValid}, 32'd0);
   endtask

   initial begin
      logic [31:0] addr, wa, line_mask;
      line_mask = 32'(DEPTH * 4 - 1) & ~32'(LW * 4 - 1);
      #2;
      reset_check();

      writeback(32'h100, 32'hA0, 1'b0);
      refill(32'h100, 0);
      refill(32'h100, 2);
      refill(32'h108, 0);
      writeback(32'h200, 32'hC0, 1'b1);
      refill(32'h200, 1);
      writeback(32'h1000, 32'hB0, 1'b0);
      refill(32'h0000, 0);
      refill(32'h100, 3);
      refill(32'h100, 0);

      written_q.push_back(32'h100);
      written_q.push_back(32'h200);
      written_q.push_back(32'h0);
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            addr = $urandom;
            writeback(addr, $urandom, 1'b1);
            written_q.push_back(addr);
         end else begin
            wa   = written_q[$urandom_range(0, written_q.size() - 1)];
            addr = ($urandom & ~line_mask) | (wa & line_mask);
            refill(addr, 1);
         end
      end

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
